adder_seq_ctrl: RTL

- Sequencer that drives the shared 6-bit combinational adder (x/y in, s/ov out, no carry-in) to perform WORDS*6-bit additions, one chunk at a time, LSB chunk first.
- The adder has no carry-in, so the sequencer injects the inter-chunk carry with a second pass that adds 1 to the partial sum.
- Sits between a valid/ready operand source and a valid/ready result sink. The adder instance is external and is wired to the add_* ports by the parent.

---
 rtl/adder_seq_ctrl_if.sv | 29 ++
 rtl/adder_seq_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/adder_seq_ctrl_if.sv
// rtl/adder_seq_ctrl_if.sv - operand/result handshake and shared-adder bus for adder_seq_ctrl
interface adder_seq_ctrl_if #(
    parameter int WORDS = 4
);
    localparam int W = 6 * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic [5:0]   add_x;
    logic [5:0]   add_y;
    logic [5:0]   add_s;
    logic         add_ov;

    modport slave (
        input  in_valid, a, b, out_ready, add_s, add_ov,
        output in_ready, out_valid, sum, cout, add_x, add_y
    );

    modport master (
        output in_valid, a, b, out_ready, add_s, add_ov,
        input  in_ready, out_valid, sum, cout, add_x, add_y
    );
endinterface

// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - chunked W-bit adder sequencer driving an external 6-bit adder without carry-in
module adder_seq_ctrl #(
    parameter int WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    adder_seq_ctrl_if.slave   bus
);
    localparam int W     = 6 * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_INC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [5:0]       tmp_q, tmp_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             c1_q, c1_d;
    logic             cout_q, cout_d;

    logic             last;
    int               sh;

    // Chunk addressing shared by the datapath and the adder drive.
    always_comb begin
        last = (idx_q == IDX_W'(WORDS - 1));
        sh   = 6 * int'(idx_q);
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            tmp_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            c1_q    <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            tmp_q   <= tmp_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            c1_q    <= c1_d;
            cout_q  <= cout_d;
        end
    end

    // Next state: a pending carry diverts the chunk through an extra +1 pass.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.in_valid) state_d = S_ADD;
            S_ADD: begin
                if (carry_q)   state_d = S_INC;
                else if (last) state_d = S_DONE;
            end
            S_INC:  state_d = last ? S_DONE : S_ADD;
            S_DONE: if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath updates: latch operands, capture adder results, propagate carry.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        tmp_d   = tmp_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        c1_d    = c1_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    idx_d   = '0;
                    carry_d = 1'b0;
                end
            end
            S_ADD: begin
                tmp_d = bus.add_s;
                c1_d  = bus.add_ov;
                if (!carry_q) begin
                    sum_d[sh +: 6] = bus.add_s;
                    carry_d        = bus.add_ov;
                    if (last) cout_d = bus.add_ov;
                    else      idx_d  = idx_q + IDX_W'(1);
                end
            end
            S_INC: begin
                // c1 and add_ov cannot both be set: the chunk sum is at most 62 here.
                sum_d[sh +: 6] = bus.add_s;
                carry_d        = c1_q | bus.add_ov;
                if (last) cout_d = c1_q | bus.add_ov;
                else      idx_d  = idx_q + IDX_W'(1);
            end
            default: ;
        endcase
    end

    // Outputs: handshakes from state, adder operands selected from registers.
    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
        bus.sum       = sum_q;
        bus.cout      = cout_q;
        bus.add_x     = 6'd0;
        bus.add_y     = 6'd0;
        case (state_q)
            S_ADD: begin
                bus.add_x = a_q[sh +: 6];
                bus.add_y = b_q[sh +: 6];
            end
            S_INC: begin
                bus.add_x = tmp_q;
                bus.add_y = 6'd1;
            end
            default: ;
        endcase
    end
endmodule
